// File: rtl/axi_lite_xbar_1xn.sv
// AXI4-Lite 1-master to N-slave crossbar with registered address decode,
// independent read/write FSMs and an internal DECERR responder for misses.
module axi_lite_xbar_1xn #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'h0001_3000, 32'h0001_2000, 32'h0001_1000, 32'h0001_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {4{32'hFFFF_F000}}
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  // master side
  input  logic [ADDR_W-1:0]              m_axi_awaddr,
  input  logic [2:0]                     m_axi_awprot,
  input  logic                           m_axi_awvalid,
  output logic                           m_axi_awready,
  input  logic [DATA_W-1:0]              m_axi_wdata,
  input  logic [DATA_W/8-1:0]            m_axi_wstrb,
  input  logic                           m_axi_wvalid,
  output logic                           m_axi_wready,
  output logic [1:0]                     m_axi_bresp,
  output logic                           m_axi_bvalid,
  input  logic                           m_axi_bready,
  input  logic [ADDR_W-1:0]              m_axi_araddr,
  input  logic [2:0]                     m_axi_arprot,
  input  logic                           m_axi_arvalid,
  output logic                           m_axi_arready,
  output logic [DATA_W-1:0]              m_axi_rdata,
  output logic [1:0]                     m_axi_rresp,
  output logic                           m_axi_rvalid,
  input  logic                           m_axi_rready,
  // slave side, slot i at [i*W +: W]
  output logic [NUM_SLAVES*ADDR_W-1:0]   s_axi_awaddr,
  output logic [NUM_SLAVES*3-1:0]        s_axi_awprot,
  output logic [NUM_SLAVES-1:0]          s_axi_awvalid,
  input  logic [NUM_SLAVES-1:0]          s_axi_awready,
  output logic [NUM_SLAVES*DATA_W-1:0]   s_axi_wdata,
  output logic [NUM_SLAVES*DATA_W/8-1:0] s_axi_wstrb,
  output logic [NUM_SLAVES-1:0]          s_axi_wvalid,
  input  logic [NUM_SLAVES-1:0]          s_axi_wready,
  input  logic [NUM_SLAVES*2-1:0]        s_axi_bresp,
  input  logic [NUM_SLAVES-1:0]          s_axi_bvalid,
  output logic [NUM_SLAVES-1:0]          s_axi_bready,
  output logic [NUM_SLAVES*ADDR_W-1:0]   s_axi_araddr,
  output logic [NUM_SLAVES*3-1:0]        s_axi_arprot,
  output logic [NUM_SLAVES-1:0]          s_axi_arvalid,
  input  logic [NUM_SLAVES-1:0]          s_axi_arready,
  input  logic [NUM_SLAVES*DATA_W-1:0]   s_axi_rdata,
  input  logic [NUM_SLAVES*2-1:0]        s_axi_rresp,
  input  logic [NUM_SLAVES-1:0]          s_axi_rvalid,
  output logic [NUM_SLAVES-1:0]          s_axi_rready
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] W_IDLE = 3'd0;
  localparam logic [2:0] W_FWD  = 3'd1;
  localparam logic [2:0] W_RESP = 3'd2;
  localparam logic [2:0] W_ERR  = 3'd3;
  localparam logic [2:0] W_ERRB = 3'd4;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_FWD  = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_ERR  = 2'd3;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  // {hit, index}; scanning downward lets the lowest matching index win.
  function automatic logic [SEL_W:0] decode(input logic [ADDR_W-1:0] addr);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        res = {1'b1, SEL_W'(i)};
      end
    end
    return res;
  endfunction

  logic [2:0]        w_state_q, w_state_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [2:0]        aw_prot_q, aw_prot_d;
  logic [SEL_W-1:0]  aw_sel_q, aw_sel_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic [1:0]        r_state_q, r_state_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [2:0]        ar_prot_q, ar_prot_d;
  logic [SEL_W-1:0]  ar_sel_q, ar_sel_d;

  logic [SEL_W:0]    aw_dec, ar_dec;
  logic              aw_ok, w_ok;

  assign aw_dec = decode(m_axi_awaddr);
  assign ar_dec = decode(m_axi_araddr);

  always_comb begin
    w_state_d     = w_state_q;
    aw_addr_d     = aw_addr_q;
    aw_prot_d     = aw_prot_q;
    aw_sel_d      = aw_sel_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    aw_ok         = 1'b0;
    w_ok          = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_bvalid  = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awprot  = '0;
    s_axi_awvalid = '0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = '0;
    s_axi_bready  = '0;
    case (w_state_q)
      W_IDLE: begin
        m_axi_awready = 1'b1;
        if (m_axi_awvalid) begin
          aw_addr_d = m_axi_awaddr;
          aw_prot_d = m_axi_awprot;
          aw_sel_d  = aw_dec[SEL_W] ? aw_dec[SEL_W-1:0] : '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = aw_dec[SEL_W] ? W_FWD : W_ERR;
        end
      end
      W_FWD: begin
        s_axi_awaddr[aw_sel_q*ADDR_W +: ADDR_W] = aw_addr_q;
        s_axi_awprot[aw_sel_q*3 +: 3]           = aw_prot_q;
        s_axi_awvalid[aw_sel_q]                 = !aw_done_q;
        s_axi_wdata[aw_sel_q*DATA_W +: DATA_W]  = m_axi_wdata;
        s_axi_wstrb[aw_sel_q*STRB_W +: STRB_W]  = m_axi_wstrb;
        s_axi_wvalid[aw_sel_q]                  = m_axi_wvalid && !w_done_q;
        m_axi_wready = s_axi_wready[aw_sel_q] && !w_done_q;
        aw_ok = aw_done_q || s_axi_awready[aw_sel_q];
        w_ok  = w_done_q || (m_axi_wvalid && m_axi_wready);
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) w_state_d = W_RESP;
      end
      W_RESP: begin
        m_axi_bvalid           = s_axi_bvalid[aw_sel_q];
        m_axi_bresp            = s_axi_bresp[aw_sel_q*2 +: 2];
        s_axi_bready[aw_sel_q] = m_axi_bready;
        if (m_axi_bvalid && m_axi_bready) w_state_d = W_IDLE;
      end
      W_ERR: begin
        m_axi_wready = 1'b1;
        if (m_axi_wvalid) w_state_d = W_ERRB;
      end
      W_ERRB: begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = RESP_DECERR;
        if (m_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d     = r_state_q;
    ar_addr_d     = ar_addr_q;
    ar_prot_d     = ar_prot_q;
    ar_sel_d      = ar_sel_q;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rvalid  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arprot  = '0;
    s_axi_arvalid = '0;
    s_axi_rready  = '0;
    case (r_state_q)
      R_IDLE: begin
        m_axi_arready = 1'b1;
        if (m_axi_arvalid) begin
          ar_addr_d = m_axi_araddr;
          ar_prot_d = m_axi_arprot;
          ar_sel_d  = ar_dec[SEL_W] ? ar_dec[SEL_W-1:0] : '0;
          r_state_d = ar_dec[SEL_W] ? R_FWD : R_ERR;
        end
      end
      R_FWD: begin
        s_axi_araddr[ar_sel_q*ADDR_W +: ADDR_W] = ar_addr_q;
        s_axi_arprot[ar_sel_q*3 +: 3]           = ar_prot_q;
        s_axi_arvalid[ar_sel_q]                 = 1'b1;
        if (s_axi_arready[ar_sel_q]) r_state_d = R_DATA;
      end
      R_DATA: begin
        m_axi_rvalid           = s_axi_rvalid[ar_sel_q];
        m_axi_rdata            = s_axi_rdata[ar_sel_q*DATA_W +: DATA_W];
        m_axi_rresp            = s_axi_rresp[ar_sel_q*2 +: 2];
        s_axi_rready[ar_sel_q] = m_axi_rready;
        if (m_axi_rvalid && m_axi_rready) r_state_d = R_IDLE;
      end
      default: begin
        m_axi_rvalid = 1'b1;
        m_axi_rresp  = RESP_DECERR;
        if (m_axi_rready) r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      aw_sel_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      r_state_q <= R_IDLE;
      ar_addr_q <= '0;
      ar_prot_q <= '0;
      ar_sel_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_addr_q <= aw_addr_d;
      aw_prot_q <= aw_prot_d;
      aw_sel_q  <= aw_sel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      r_state_q <= r_state_d;
      ar_addr_q <= ar_addr_d;
      ar_prot_q <= ar_prot_d;
      ar_sel_q  <= ar_sel_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_xbar_1xn.sv
// Directed bench for axi_lite_xbar_1xn: slaves are driven step by step from one
// initial block and every expectation is a hand-computed constant.
module tb_axi_lite_xbar_1xn;

  logic         aclk;
  logic         aresetn;
  logic [31:0]  m_axi_awaddr;
  logic [2:0]   m_axi_awprot;
  logic         m_axi_awvalid;
  logic         m_axi_awready;
  logic [31:0]  m_axi_wdata;
  logic [3:0]   m_axi_wstrb;
  logic         m_axi_wvalid;
  logic         m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid;
  logic         m_axi_bready;
  logic [31:0]  m_axi_araddr;
  logic [2:0]   m_axi_arprot;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [31:0]  m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rvalid;
  logic         m_axi_rready;
  logic [127:0] s_axi_awaddr;
  logic [11:0]  s_axi_awprot;
  logic [3:0]   s_axi_awvalid;
  logic [3:0]   s_axi_awready;
  logic [127:0] s_axi_wdata;
  logic [15:0]  s_axi_wstrb;
  logic [3:0]   s_axi_wvalid;
  logic [3:0]   s_axi_wready;
  logic [7:0]   s_axi_bresp;
  logic [3:0]   s_axi_bvalid;
  logic [3:0]   s_axi_bready;
  logic [127:0] s_axi_araddr;
  logic [11:0]  s_axi_arprot;
  logic [3:0]   s_axi_arvalid;
  logic [3:0]   s_axi_arready;
  logic [127:0] s_axi_rdata;
  logic [7:0]   s_axi_rresp;
  logic [3:0]   s_axi_rvalid;
  logic [3:0]   s_axi_rready;

  int checks   = 0;
  int failures = 0;
  logic b_done, r_done;

  axi_lite_xbar_1xn dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leave 1 time unit after the edge so inputs change away from it.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn = 1'b0;
    m_axi_awaddr = '0; m_axi_awprot = '0; m_axi_awvalid = 1'b0;
    m_axi_wdata = '0; m_axi_wstrb = '0; m_axi_wvalid = 1'b0; m_axi_bready = 1'b0;
    m_axi_araddr = '0; m_axi_arprot = '0; m_axi_arvalid = 1'b0; m_axi_rready = 1'b0;
    s_axi_awready = '0; s_axi_wready = '0; s_axi_bresp = '0; s_axi_bvalid = '0;
    s_axi_arready = '0; s_axi_rdata = '0; s_axi_rresp = '0; s_axi_rvalid = '0;

    // Reset state
    step(); step();
    chk("rst_awready", m_axi_awready, 1);
    chk("rst_arready", m_axi_arready, 1);
    chk("rst_wready", m_axi_wready, 0);
    chk("rst_bvalid", m_axi_bvalid, 0);
    chk("rst_rvalid", m_axi_rvalid, 0);
    chk("rst_s_valids", {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid}, 0);
    chk("rst_s_readys", {s_axi_bready, s_axi_rready}, 0);
    aresetn = 1'b1;
    step();

    // Write 0x0001_2004 to slave 2, ready immediately
    m_axi_awaddr = 32'h0001_2004; m_axi_awprot = 3'b010; m_axi_awvalid = 1'b1;
    m_axi_wdata = 32'hDEAD_BEEF; m_axi_wstrb = 4'hF; m_axi_wvalid = 1'b1;
    s_axi_awready = 4'b0100; s_axi_wready = 4'b0100;
    #1;
    chk("w1_idle_awready", m_axi_awready, 1);
    chk("w1_idle_wready", m_axi_wready, 0);
    chk("w1_idle_s_awvalid", s_axi_awvalid, 0);
    step();
    m_axi_awvalid = 1'b0;
    #1;
    chk("w1_s_awvalid", s_axi_awvalid, 4'b0100);
    chk("w1_s_awaddr", s_axi_awaddr[64 +: 32], 32'h0001_2004);
    chk("w1_s_awprot", s_axi_awprot[6 +: 3], 3'b010);
    chk("w1_s_wvalid", s_axi_wvalid, 4'b0100);
    chk("w1_s_wdata", s_axi_wdata[64 +: 32], 32'hDEAD_BEEF);
    chk("w1_s_wstrb", s_axi_wstrb[8 +: 4], 4'hF);
    chk("w1_m_wready", m_axi_wready, 1);
    chk("w1_awready_busy", m_axi_awready, 0);
    step();
    m_axi_wvalid = 1'b0; s_axi_awready = '0; s_axi_wready = '0;
    s_axi_bvalid = 4'b0100; s_axi_bresp = '0; m_axi_bready = 1'b1;
    #1;
    chk("w1_s_awvalid_done", s_axi_awvalid, 0);
    chk("w1_bvalid", m_axi_bvalid, 1);
    chk("w1_bresp", m_axi_bresp, 2'b00);
    chk("w1_s_bready", s_axi_bready, 4'b0100);
    step();
    s_axi_bvalid = '0; m_axi_bready = 1'b0;
    #1;
    chk("w1_back_idle", m_axi_awready, 1);

    // Read 0x0001_0010 from slave 0 with a 3-cycle arready stall
    m_axi_araddr = 32'h0001_0010; m_axi_arvalid = 1'b1;
    step();
    m_axi_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("r1_stall_arvalid", s_axi_arvalid, 4'b0001);
      chk("r1_stall_araddr", s_axi_araddr[0 +: 32], 32'h0001_0010);
      chk("r1_stall_arready", m_axi_arready, 0);
      step();
    end
    s_axi_arready = 4'b0001;
    #1;
    chk("r1_arvalid_hs", s_axi_arvalid, 4'b0001);
    step();
    s_axi_arready = '0;
    s_axi_rvalid = 4'b0001; s_axi_rdata[0 +: 32] = 32'h1234_5678; s_axi_rresp = '0;
    m_axi_rready = 1'b1;
    #1;
    chk("r1_s_arvalid_off", s_axi_arvalid, 0);
    chk("r1_rvalid", m_axi_rvalid, 1);
    chk("r1_rdata", m_axi_rdata, 32'h1234_5678);
    chk("r1_rresp", m_axi_rresp, 2'b00);
    chk("r1_s_rready", s_axi_rready, 4'b0001);
    step();
    s_axi_rvalid = '0; m_axi_rready = 1'b0;
    #1;
    chk("r1_back_idle", m_axi_arready, 1);

    // Unmapped read
    m_axi_araddr = 32'h0002_0000; m_axi_arvalid = 1'b1;
    step();
    m_axi_arvalid = 1'b0;
    #1;
    chk("rerr_rvalid", m_axi_rvalid, 1);
    chk("rerr_rdata", m_axi_rdata, 0);
    chk("rerr_rresp", m_axi_rresp, 2'b11);
    chk("rerr_s_arvalid", s_axi_arvalid, 0);
    step();
    #1;
    chk("rerr_hold_rvalid", m_axi_rvalid, 1);
    m_axi_rready = 1'b1;
    step();
    m_axi_rready = 1'b0;
    #1;
    chk("rerr_done_rvalid", m_axi_rvalid, 0);
    chk("rerr_arready", m_axi_arready, 1);

    // Unmapped write
    m_axi_awaddr = 32'h0002_0000; m_axi_awvalid = 1'b1;
    step();
    m_axi_awvalid = 1'b0;
    m_axi_wdata = 32'h0BAD_0BAD; m_axi_wvalid = 1'b1;
    #1;
    chk("werr_wready", m_axi_wready, 1);
    chk("werr_s_wvalid", s_axi_wvalid, 0);
    chk("werr_s_awvalid", s_axi_awvalid, 0);
    chk("werr_bvalid_early", m_axi_bvalid, 0);
    step();
    m_axi_wvalid = 1'b0;
    #1;
    chk("werr_bvalid", m_axi_bvalid, 1);
    chk("werr_bresp", m_axi_bresp, 2'b11);
    m_axi_bready = 1'b1;
    step();
    m_axi_bready = 1'b0;
    #1;
    chk("werr_bvalid_off", m_axi_bvalid, 0);
    chk("werr_awready", m_axi_awready, 1);

    // W two cycles ahead of AW, then slave 1 accepts AW and W together
    m_axi_wdata = 32'hA5A5_5A5A; m_axi_wstrb = 4'h3; m_axi_wvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("wfirst_wready", m_axi_wready, 0);
      step();
    end
    m_axi_awaddr = 32'h0001_1008; m_axi_awvalid = 1'b1;
    #1;
    chk("wfirst_wready_aw", m_axi_wready, 0);
    step();
    m_axi_awvalid = 1'b0;
    s_axi_awready = 4'b0010; s_axi_wready = 4'b0010;
    #1;
    chk("wfirst_s_awvalid", s_axi_awvalid, 4'b0010);
    chk("wfirst_s_wvalid", s_axi_wvalid, 4'b0010);
    chk("wfirst_s_wdata", s_axi_wdata[32 +: 32], 32'hA5A5_5A5A);
    chk("wfirst_wready_fwd", m_axi_wready, 1);
    step();
    m_axi_wvalid = 1'b0; s_axi_awready = '0; s_axi_wready = '0;
    s_axi_bvalid = 4'b0010; s_axi_bresp = 8'h00; m_axi_bready = 1'b1;
    #1;
    chk("wfirst_s_valids_off", {s_axi_awvalid, s_axi_wvalid}, 0);
    chk("wfirst_bvalid", m_axi_bvalid, 1);
    step();
    s_axi_bvalid = '0; m_axi_bready = 1'b0;
    #1;
    chk("wfirst_single_b", m_axi_bvalid, 0);
    chk("wfirst_idle", m_axi_awready, 1);

    // Concurrent write to slave 3 and read from slave 1, throttled ready
    m_axi_awaddr = 32'h0001_3010; m_axi_awvalid = 1'b1;
    m_axi_wdata = 32'h1122_3344; m_axi_wstrb = 4'hF; m_axi_wvalid = 1'b1;
    m_axi_araddr = 32'h0001_1020; m_axi_arvalid = 1'b1;
    s_axi_awready = 4'b1000; s_axi_wready = 4'b1000; s_axi_arready = 4'b0010;
    step();
    m_axi_awvalid = 1'b0; m_axi_arvalid = 1'b0;
    #1;
    chk("conc_s_awvalid", s_axi_awvalid, 4'b1000);
    chk("conc_s_awaddr", s_axi_awaddr[96 +: 32], 32'h0001_3010);
    chk("conc_s_wdata", s_axi_wdata[96 +: 32], 32'h1122_3344);
    chk("conc_s_arvalid", s_axi_arvalid, 4'b0010);
    chk("conc_s_araddr", s_axi_araddr[32 +: 32], 32'h0001_1020);
    step();
    m_axi_wvalid = 1'b0; s_axi_awready = '0; s_axi_wready = '0; s_axi_arready = '0;
    s_axi_bvalid = 4'b1000; s_axi_bresp = 8'h00;
    s_axi_rvalid = 4'b0010; s_axi_rdata[32 +: 32] = 32'hCAFE_F00D; s_axi_rresp = 8'h00;
    b_done = 1'b0; r_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      m_axi_bready = (i >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
      m_axi_rready = (i >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (!b_done) begin
        chk("conc_b_hold", m_axi_bvalid, 1);
        if (m_axi_bready) begin
          chk("conc_bresp", m_axi_bresp, 2'b00);
          chk("conc_s_bready", s_axi_bready, 4'b1000);
          b_done = 1'b1;
        end
      end
      if (!r_done) begin
        chk("conc_r_hold", m_axi_rvalid, 1);
        if (m_axi_rready) begin
          chk("conc_rdata", m_axi_rdata, 32'hCAFE_F00D);
          chk("conc_s_rready", s_axi_rready, 4'b0010);
          r_done = 1'b1;
        end
      end
      step();
      if (b_done) s_axi_bvalid = '0;
      if (r_done) s_axi_rvalid = '0;
      if (b_done && r_done) break;
    end
    m_axi_bready = 1'b0; m_axi_rready = 1'b0;
    #1;
    chk("conc_both_done", {b_done, r_done}, 2'b11);
    chk("conc_idle", {m_axi_awready, m_axi_arready}, 2'b11);

    // Reset during W_FWD (slave 0) and R_DATA (slave 2)
    m_axi_awaddr = 32'h0001_0000; m_axi_awvalid = 1'b1;
    m_axi_araddr = 32'h0001_2000; m_axi_arvalid = 1'b1;
    s_axi_arready = 4'b0100;
    step();
    m_axi_awvalid = 1'b0; m_axi_arvalid = 1'b0;
    #1;
    chk("rstmid_s_awvalid", s_axi_awvalid, 4'b0001);
    chk("rstmid_s_arvalid", s_axi_arvalid, 4'b0100);
    step();
    s_axi_arready = '0;
    s_axi_rvalid = 4'b0100; s_axi_rdata[64 +: 32] = 32'h0000_0055;
    #1;
    chk("rstmid_pre_rvalid", m_axi_rvalid, 1);
    chk("rstmid_pre_awvalid", s_axi_awvalid, 4'b0001);
    chk("rstmid_pre_busy", {m_axi_awready, m_axi_arready}, 2'b00);
    aresetn = 1'b0;
    s_axi_rvalid = '0; s_axi_rdata = '0;
    #1;
    chk("rstmid_s_valids", {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid}, 0);
    chk("rstmid_m_valids", {m_axi_bvalid, m_axi_rvalid, m_axi_wready}, 0);
    chk("rstmid_s_awaddr", s_axi_awaddr, 0);
    step();
    aresetn = 1'b1;
    #1;
    chk("rstmid_after_ready", {m_axi_awready, m_axi_arready}, 2'b11);
    m_axi_araddr = 32'h0001_3004; m_axi_arvalid = 1'b1;
    step();
    m_axi_arvalid = 1'b0; s_axi_arready = 4'b1000;
    #1;
    chk("post_s_arvalid", s_axi_arvalid, 4'b1000);
    step();
    s_axi_arready = '0;
    s_axi_rvalid = 4'b1000; s_axi_rdata[96 +: 32] = 32'h0BAD_F00D; m_axi_rready = 1'b1;
    #1;
    chk("post_rdata", m_axi_rdata, 32'h0BAD_F00D);
    chk("post_rvalid", m_axi_rvalid, 1);
    step();
    s_axi_rvalid = '0; m_axi_rready = 1'b0;
    #1;
    chk("post_idle", m_axi_arready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_xbar_1xn.md
# axi_lite_xbar_1xn

Parametrised AXI4-Lite 1-master-to-N-slave interconnect with registered address decode, independent read and write channels, and an internal DECERR responder for unmapped addresses. It sits between the CPU data port and the peripheral slaves, and generalises the single-slave crossbar to N slaves with configurable address and data widths. Each direction allows one outstanding transaction. Read and write transactions may be in flight at the same time.

## Interface
Parameters:
- NUM_SLAVES, default 4, number of slave ports (1..16).
- ADDR_W, default 32, address width.
- DATA_W, default 32, data width (32 or 64). Strobe width is DATA_W/8.
- SLAVE_BASE, default {32'h0001_3000, 32'h0001_2000, 32'h0001_1000, 32'h0001_0000}, packed NUM_SLAVES×ADDR_W array of base addresses; slot 0 is the rightmost entry.
- SLAVE_MASK, default {4{32'hFFFF_F000}}, packed NUM_SLAVES×ADDR_W array of decode masks. Slave i matches when (addr & mask[i]) == base[i].

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- m_axi_aw{addr,prot,valid}/awready: in/in/in/out, widths ADDR_W/3/1/1, master write address.
- m_axi_w{data,strb,valid}/wready: in/in/in/out, widths DATA_W/DATA_W/8/1/1, master write data.
- m_axi_b{resp,valid}/bready: out/out/in, widths 2/1/1, master write response.
- m_axi_ar{addr,prot,valid}/arready: in/in/in/out, widths ADDR_W/3/1/1, master read address.
- m_axi_r{data,resp,valid}/rready: out/out/out/in, widths DATA_W/2/1/1, master read data.
- s_axi_*: the same five channels with directions mirrored. Each signal is a flattened vector of NUM_SLAVES×(per-slave width); slave i occupies bits [i*W +: W].

## Operation
Decode:
- Lowest-index matching slave wins when address ranges overlap.
- No match selects the internal error slave.
- The selected index and the address/prot are registered at address acceptance. The slave path is never driven combinationally from the master address.

Write FSM:
- W_IDLE: m_axi_awready=1. On AW handshake, latch addr/prot/select, clear aw_done/w_done, then go to W_FWD, or to W_ERR on a decode miss.
- W_FWD: s_axi_awvalid[sel] is driven from the latched address until s_axi_awready[sel], which sets aw_done. W is passed through (s_wvalid[sel]=m_wvalid, m_wready=s_wready[sel]) until the handshake, which sets w_done. When both flags are set (including the same-cycle case), go to W_RESP.
- W_RESP: B is passed through from slave sel. On m_bvalid&&m_bready, return to W_IDLE.
- W_ERR: m_wready=1. On W handshake, go to W_ERRB. The data is discarded.
- W_ERRB: m_bvalid=1, m_bresp=2'b11. On bready, return to W_IDLE.

Read FSM:
- R_IDLE: m_arready=1. On AR handshake, latch and go to R_FWD, or to R_ERR on a decode miss.
- R_FWD: s_arvalid[sel] is held until s_arready[sel], then go to R_DATA.
- R_DATA: R is passed through from slave sel. On m_rvalid&&m_rready, return to R_IDLE.
- R_ERR: m_rvalid=1, m_rdata=0, m_rresp=2'b11. On rready, return to R_IDLE.

Non-selected slaves always see valid=0 and ready=0.

## Timing
- Reset (asynchronous, immediate): both FSMs go to IDLE and all latched registers are cleared.
  - Outputs during reset: m_awready=1, m_arready=1 (after deassertion). m_wready, m_bvalid and m_rvalid are 0. All s_*valid and s_*ready are 0. Data and resp are 0.
- Reset mid-transaction aborts the transaction with no response issued. The slave must be reset by the same aresetn.
- Latency: an AW or AR handshake in cycle N produces the slave-side valid in cycle N+1.
  - W, B and R are combinational passthrough with zero added latency.
  - Minimum write: 3 cycles from AW to B. Minimum read: 3 cycles from AR to R.
  - DECERR read: rvalid in cycle N+1. DECERR write: bvalid one cycle after the W handshake.
- W arriving before AW: m_wready=0 in W_IDLE, so W is stalled until the AW is accepted.
- Valid signals, once asserted by the block, stay high until the handshake; the block never retracts them.
- The master sees m_awready=0 from W_FWD until W_IDLE; AR is treated the same way.

## Test plan
- Write to 0x0001_2004 with data 0xDEADBEEF and strb 0xF, with slave 2 ready immediately. Required: s_awaddr slot 2 = 0x0001_2004 one cycle after the AW handshake, slave 2 receives the W data, m_bresp=0, and no other slave sees a valid.
- Read 0x0001_0010 while slave 0 holds arready low for 3 cycles and then returns 0x12345678. Required: s_arvalid[0] stays high through the stall, and m_rdata=0x12345678 with rresp=0.
- Read 0x0002_0000 (unmapped). Required: rvalid next cycle, rdata=0, rresp=2'b11, and no slave valid asserted. Unmapped write: W is consumed and bresp=2'b11.
- W presented two cycles before AW, then aw/w accepted by slave 1 in the same cycle. Required: wready=0 until AW is accepted, a single B is returned, and the FSM is back in IDLE.
- Concurrent write to slave 3 and read from slave 1 with bready/rready randomly throttled. Required: both transactions complete independently with correct data.
- Assert aresetn low while in W_FWD and R_DATA. Required: all valids drop in the same cycle, and after release awready=arready=1 and a new transfer completes normally.
